// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Front-end PC/pipeline control: redirects, I-cache miss stall,
//             exception drain. Optional stall counter via FETCH_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned EXC_DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        branch_taken,
    input  logic        jump_req,
    input  logic        load_use_hazard,
    input  logic        icache_hit,
    input  logic        refill_done,
    output logic        is_exception,
    output logic        is_branch,
    output logic        is_jump,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        stall_all,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MISS    = 2'd1;
    localparam logic [1:0] ST_EXC     = 2'd2;
    localparam logic [2:0] DRAIN_LOAD = 3'(EXC_DRAIN_CYCLES);

    logic [1:0] state_q;
    logic [1:0] next_state;
    logic       pending_exc;
    logic       pending_next;
    logic [2:0] drain_cnt;
    logic [2:0] drain_next;

    assign state = state_q;

    always_comb begin
        is_exception = 1'b0;
        is_branch    = 1'b0;
        is_jump      = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        stall_all    = 1'b0;
        next_state   = ST_RUN;
        pending_next = pending_exc;
        drain_next   = drain_cnt;

        case (state_q)
            ST_RUN: begin
                next_state = ST_RUN;
                if (exc_req || pending_exc) begin
                    is_exception = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    pending_next = 1'b0;
                    next_state   = ST_EXC;
                    drain_next   = DRAIN_LOAD;
                end else if (branch_taken) begin
                    is_branch   = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (jump_req) begin
                    is_jump     = 1'b1;
                    flush_if_id = 1'b1;
                end else if (!icache_hit) begin
                    // Miss wins over a load-use bubble: the whole pipe freezes,
                    // so the hazard is still there when the miss resolves.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    stall_all   = 1'b1;
                    next_state  = ST_MISS;
                end else if (load_use_hazard) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    flush_id_ex = 1'b1;
                end
            end
            ST_MISS: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                stall_all   = 1'b1;
                next_state  = refill_done ? ST_RUN : ST_MISS;
                if (exc_req) begin
                    pending_next = 1'b1;
                end
            end
            ST_EXC: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (drain_cnt <= 3'd1) begin
                    next_state = ST_RUN;
                    drain_next = 3'd0;
                end else begin
                    next_state = ST_EXC;
                    drain_next = drain_cnt - 3'd1;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase

        // Reset forces the idle-RUN output set regardless of the current state.
        if (reset) begin
            is_exception = 1'b0;
            is_branch    = 1'b0;
            is_jump      = 1'b0;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            stall_all    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pending_exc <= 1'b0;
            drain_cnt   <= 3'd0;
        end else begin
            state_q     <= next_state;
            pending_exc <= pending_next;
            drain_cnt   <= drain_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter EXC_DRAIN_CYCLES, default 2, range 1-7: cycles held in EXC state after exception redirect.
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have: exc_req  input  1  exception/interrupt request from any stage.
REQ-005 SHALL have: branch_taken  input  1  taken branch resolved in EX.
REQ-006 SHALL have: jump_req  input  1  jump decoded in ID.
REQ-007 SHALL have: load_use_hazard  input  1  load-use dependency detected in ID.
REQ-008 SHALL have: icache_hit  input  1  current fetch hits instruction cache.
REQ-009 SHALL have: refill_done  input  1  single-cycle pulse, cache line refill complete.
REQ-010 SHALL have: is_exception, is_branch, is_jump  output  1 each  PC next-value selects, at most one high per cycle.
REQ-011 SHALL have: pc_write  output  1  PC register write enable.
REQ-012 SHALL have: if_id_write  output  1  IF/ID register write enable.
REQ-013 SHALL have: flush_if_id, flush_id_ex  output  1 each  pipeline-register flushes.
REQ-014 SHALL have: stall_all  output  1  freezes ID/EX/MEM/WB during cache miss.
REQ-015 SHALL have: state  output  2  current state (RUN=0, MISS=1, EXC=2).
REQ-016 SHALL have: stall_cnt  output  32  front-end stall cycle counter.

Function
REQ-017 SHALL implement states RUN, MISS, EXC; selects, pc_write and flush outputs combinational from state and inputs; state registered.
REQ-018 In RUN, redirect priority SHALL be exception (exc_req or pending_exc) > branch_taken > jump_req; exactly one select asserted, pc_write=1, if_id_write=1.
REQ-019 Exception in RUN: is_exception=1, flush_if_id=1, flush_id_ex=1, clear pending_exc, next state EXC, drain counter loaded with EXC_DRAIN_CYCLES.
REQ-020 Branch in RUN: is_branch=1, flush_if_id=1, flush_id_ex=1, state stays RUN.
REQ-021 Jump in RUN (no exception/branch): is_jump=1, flush_if_id=1, flush_id_ex=0.
REQ-022 load_use_hazard in RUN without redirect: pc_write=0, if_id_write=0, flush_id_ex=1; branch or exception overrides the hazard.
REQ-023 icache_hit=0 in RUN without redirect: pc_write=0, if_id_write=0, stall_all=1, next state MISS; a redirect in the same cycle wins and the miss is ignored.
REQ-024 In MISS: pc_write=0, if_id_write=0, stall_all=1, all selects 0; branch_taken/jump_req ignored (held by frozen pipeline).
REQ-025 In MISS, exc_req SHALL set pending_exc; pending_exc is taken in the first RUN cycle after the miss.
REQ-026 In MISS, refill_done=1 SHALL transition to RUN; that cycle still has pc_write=0, stall_all=1.
REQ-027 In EXC: pc_write=0, if_id_write=0, flush_if_id=1, flush_id_ex=1; drain counter decrements each cycle; at count 1 next state RUN.
REQ-028 exc_req during EXC SHALL be ignored (no nesting, no pending set).
REQ-029 Illegal state encoding 3 SHALL transition to RUN next cycle with all outputs as in RUN with no requests.

Reset
REQ-030 With reset=1: state=RUN, pending_exc=0, drain counter=0, stall_cnt=0; outputs pc_write=1, if_id_write=1, all selects/flushes/stall_all=0.
REQ-031 Reset SHALL abort MISS or EXC immediately; pending_exc discarded.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: stall_cnt increments by 1 each non-reset cycle with pc_write=0, saturating at 0xFFFFFFFF.
REQ-033 FETCH_PERF_CNT_EN undefined: stall_cnt port present, tied to 0, no counter register.

Verification
REQ-034 Reset release, icache_hit=1, no requests for 5 cycles -> pc_write=1 every cycle, state=0, all flushes 0.
REQ-035 branch_taken=1 and jump_req=1 same cycle -> is_branch=1, is_jump=0, flush_if_id=1, flush_id_ex=1.
REQ-036 icache_hit=0 at cycle 0, refill_done at cycle 4 -> state=1 cycles 1-4, pc_write=0 cycles 0-4, pc_write=1 cycle 5; with FETCH_PERF_CNT_EN stall_cnt=5.
REQ-037 exc_req at cycle 2 of a miss, refill_done at cycle 4 -> is_exception=1 cycle 5, state=2 cycles 6-7, state=0 cycle 8.
REQ-038 load_use_hazard=1 and exc_req=1 same cycle -> is_exception=1, pc_write=1; EXC_DRAIN_CYCLES=3 gives 3 EXC cycles.
REQ-039 reset asserted mid-EXC -> next cycle state=0, pc_write=1, flushes 0.
